// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: one shared free-running counter, per-channel rising-edge taps
// producing 1-cycle clock enables. Optional counter freeze input under TICK_SCHED_PAUSE_EN.

module tick_sched_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_pause,
    input  logic             i_wr,
    input  logic [4:0]       i_tap,
    input  logic             i_mode,
    input  logic             i_en,
    output logic             o_tick,
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic [1:0] {OFF, RUN, SHOT} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t     r_state;
    logic [4:0] r_tap;
    logic       r_prev;
    logic       r_tick;
    logic       r_busy;
    logic       r_done;

    logic w_bit;
    logic w_new_bit;
    logic w_edge;

    assign w_bit     = |(i_cnt & (ONE << r_tap));
    assign w_new_bit = |(i_cnt & (ONE << i_tap));
    // A frozen counter can never produce an edge; prev is held alongside it.
    assign w_edge    = w_bit & ~r_prev & ~i_pause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OFF;
            r_tap   <= '0;
            r_prev  <= 1'b0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Tick uses the pre-transfer config even in a transfer cycle.
            r_tick <= w_edge & (r_state != OFF);
            if (i_wr) begin
                r_state <= i_en ? (i_mode ? SHOT : RUN) : OFF;
                r_busy  <= i_en;
                r_tap   <= i_tap;
                r_prev  <= w_new_bit;
                r_done  <= 1'b0;
            end else begin
                if (!i_pause)
                    r_prev <= w_bit;
                if (r_state == SHOT && w_edge) begin
                    r_state <= OFF;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_busy = r_busy;
    assign o_done = r_done;
endmodule

module tick_sched #(
    parameter int CNT_W = 32,
    parameter int NCH   = 4
) (
    input  logic           clk,
    input  logic           rst,
`ifdef TICK_SCHED_PAUSE_EN
    input  logic           pause,
`endif
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [1:0]     cfg_ch,
    input  logic [4:0]     cfg_tap,
    input  logic           cfg_mode,
    input  logic           cfg_en,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);
    localparam logic [4:0] TAP_MAX = 5'(CNT_W - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_cfg_ready;
    logic             w_pause;
    logic             w_xfer;
    logic [4:0]       w_tap;
    logic [NCH-1:0]   w_wr;

`ifdef TICK_SCHED_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_xfer    = cfg_valid & r_cfg_ready;
    assign w_tap     = (cfg_tap > TAP_MAX) ? TAP_MAX : cfg_tap;
    assign cfg_ready = r_cfg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_cfg_ready <= 1'b1;
        end else begin
            if (!w_pause)
                r_cnt <= r_cnt + 1'b1;
            // One dead cycle after every accepted request.
            r_cfg_ready <= ~w_xfer;
        end
    end

    // Requests to channels >= NCH match no lane and are silently dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_wr[g] = w_xfer && (cfg_ch == 2'(g));

        tick_sched_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_cnt   (r_cnt),
            .i_pause (w_pause),
            .i_wr    (w_wr[g]),
            .i_tap   (w_tap),
            .i_mode  (cfg_mode),
            .i_en    (cfg_en),
            .o_tick  (tick[g]),
            .o_busy  (busy[g]),
            .o_done  (done[g])
        );
    end
endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched (CNT_W=8, NCH=3); sample index cyc equals the counter value.

module tb_tick_sched;
    localparam int CNT_W = 8;
    localparam int NCH   = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
`ifdef TICK_SCHED_PAUSE_EN
    logic           pause = 1'b0;
`endif
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [4:0]     cfg_tap = '0;
    logic           cfg_mode = 1'b0;
    logic           cfg_en = 1'b0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ntick [NCH];
    int tlast [NCH];
    int tprev [NCH];
    int n0, kk;

    tick_sched #(.CNT_W(CNT_W), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TICK_SCHED_PAUSE_EN
        .pause     (pause),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_tap   (cfg_tap),
        .cfg_mode  (cfg_mode),
        .cfg_en    (cfg_en),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NCH; i++)
                if (tick[i]) begin
                    ntick[i]++;
                    tprev[i] = tlast[i];
                    tlast[i] = cyc;
                end
        end
    endtask

    task automatic align(input int m, input int r);
        step(1);
        while (cyc % m != r) step(1);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [4:0] tap, input logic mode, input logic en);
        chk("cfg_ready_before", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_tap   = tap;
        cfg_mode  = mode;
        cfg_en    = en;
        step(1);
        cfg_valid = 1'b0;
        chk("cfg_ready_after", int'(cfg_ready), 0);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            ntick[i] = 0;
            tlast[i] = 0;
            tprev[i] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        rst = 1'b0;
        cyc = 0;

        // Periodic tap0: period 2
        cfg(2'd0, 5'd0, 1'b0, 1'b1);
        chk("t1_busy0", int'(busy[0]), 1);
        n0 = ntick[0];
        step(10);
        chk("t1_count10", ntick[0] - n0, 5);
        chk("t1_period", tlast[0] - tprev[0], 2);

        // One-shot tap3, started with counter at a multiple of 16
        align(16, 0);
        cfg(2'd1, 5'd3, 1'b1, 1'b1);
        n0 = ntick[1];
        step(7);
        chk("t2_busy_pre", int'(busy[1]), 1);
        chk("t2_done_pre", int'(done[1]), 0);
        chk("t2_notick_pre", ntick[1] - n0, 0);
        step(1);
        chk("t2_tick", int'(tick[1]), 1);
        chk("t2_done", int'(done[1]), 1);
        chk("t2_busy_post", int'(busy[1]), 0);
        step(100);
        chk("t2_single", ntick[1] - n0, 1);
        chk("t2_done_hold", int'(done[1]), 1);

        // Retarget ch0 tap0 -> tap2
        align(8, 0);
        n0 = ntick[0];
        cfg(2'd0, 5'd2, 1'b0, 1'b1);
        kk = cyc;
        step(2);
        chk("t3_quiet", ntick[0] - n0, 0);
        step(2);
        chk("t3_first", tlast[0], kk + 4);
        step(8);
        chk("t3_second", tlast[0], kk + 12);
        chk("t3_period", tlast[0] - tprev[0], 8);

        // Held valid for 4 cycles: ready 1,0,1,0; ch3 discarded, ch2 started
        chk("t4_ready0", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_ch = 2'd3; cfg_tap = 5'd0; cfg_mode = 1'b0; cfg_en = 1'b1;
        step(1);
        chk("t4_ready1", int'(cfg_ready), 0);
        chk("t4_busy_ch3", int'(busy), 1);
        chk("t4_done_ch3", int'(done), 2);
        cfg_ch = 2'd2; cfg_tap = 5'd1;
        step(1);
        chk("t4_ready2", int'(cfg_ready), 1);
        chk("t4_ignored", int'(busy[2]), 0);
        step(1);
        chk("t4_ready3", int'(cfg_ready), 0);
        chk("t4_busy_ch2", int'(busy), 5);
        step(1);
        cfg_valid = 1'b0;
        chk("t4_ready4", int'(cfg_ready), 1);

        // Any cfg to a channel clears its done
        cfg(2'd1, 5'd0, 1'b0, 1'b0);
        chk("clr_done1", int'(done[1]), 0);
        chk("clr_busy1", int'(busy[1]), 0);

        // Tap 20 clamps to 7: period 256
        align(256, 0);
        n0 = ntick[2];
        cfg(2'd2, 5'd20, 1'b0, 1'b1);
        kk = cyc;
        step(127);
        chk("clamp_quiet", ntick[2] - n0, 0);
        step(1);
        chk("clamp_first", tlast[2], kk + 128);
        step(256);
        chk("clamp_second", tlast[2], kk + 384);

        // Mid-run async reset
        cfg(2'd1, 5'd0, 1'b1, 1'b1);
        step(4);
        chk("t5_done_set", int'(done[1]), 1);
        for (int i = 0; i < 8 && !tick[0]; i++) step(1);
        chk("t5_tick_pre", int'(tick[0]), 1);
        rst = 1'b1;
        #1;
        chk("t5_tick_clr", int'(tick), 0);
        chk("t5_busy_clr", int'(busy), 0);
        chk("t5_done_clr", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        chk("t5_ready", int'(cfg_ready), 1);
        n0 = ntick[0];
        cfg(2'd0, 5'd1, 1'b0, 1'b1);
        step(2);
        chk("t5_restart_tick", tlast[0], 3);
        chk("t5_restart_cnt", ntick[0] - n0, 1);
        step(2);
        cfg(2'd0, 5'd1, 1'b0, 1'b0);
        chk("t5_stop_busy", int'(busy[0]), 0);
        n0 = ntick[0];
        step(12);
        chk("t5_stop_ticks", ntick[0] - n0, 0);

`ifdef TICK_SCHED_PAUSE_EN
        cfg(2'd0, 5'd1, 1'b0, 1'b1);
        step(8);
        pause = 1'b1;
        n0 = ntick[0];
        step(20);
        chk("t6_paused", ntick[0] - n0, 0);
        chk("t6_busy", int'(busy[0]), 1);
        pause = 1'b0;
        step(4);
        chk("t6_resume", int'(ntick[0] - n0 >= 1), 1);
        step(8);
        chk("t6_period", tlast[0] - tprev[0], 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
